// File: rtl/raster_addr_gen_pkg.sv
// Shared definitions for the deskew datapath: FSM state encoding and the
// default coordinate/address widths agreed with the memory controller.
package deskew_pkg;

    localparam int DEF_X_WIDTH    = 9;
    localparam int DEF_Y_WIDTH    = 9;
    localparam int DEF_ADDR_WIDTH = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/raster_addr_gen_if.sv
// Beat bus of the raster address generator: one (x, y, addr) beat per
// valid/ready transfer, plus line and frame markers travelling with the beat.
interface raster_addr_gen_if
    import deskew_pkg::*;
#(
    parameter int X_WIDTH    = DEF_X_WIDTH,
    parameter int Y_WIDTH    = DEF_Y_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  valid;
    logic                  ready;
    logic [X_WIDTH-1:0]    x;
    logic [Y_WIDTH-1:0]    y;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  line_end;
    logic                  frame_end;

    // Generator side
    modport master (
        output valid, x, y, addr, line_end, frame_end,
        input  ready
    );

    // Memory-port side
    modport slave (
        input  valid, x, y, addr, line_end, frame_end,
        output ready
    );

endinterface

// File: rtl/raster_addr_gen_axis_counter.sv
// Single raster axis counter: clears, loads zero or increments, and flags
// when the count equals the supplied maximum.
module axis_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sclr,
    input  logic             i_load_zero,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear and load-zero take priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_sclr || i_load_zero) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_max);

endmodule

// File: rtl/raster_addr_gen.sv
// Window-aware X/Y raster walker producing (x, y, linear address) beats with
// back-pressure. The address is built incrementally from a per-line base, so
// no multiplier is needed; arithmetic wraps silently modulo 2^ADDR_WIDTH.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | waiting for start, outputs quiet
//   ST_RUN  | beat on the bus, advances on each valid&&ready
//   ST_DONE | one-cycle done pulse, then back to idle
module raster_addr_gen
    import deskew_pkg::*;
#(
    parameter int X_WIDTH    = DEF_X_WIDTH,
    parameter int Y_WIDTH    = DEF_Y_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclr,
    input  logic                  start,
    input  logic [X_WIDTH-1:0]    win_w,
    input  logic [Y_WIDTH-1:0]    win_h,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic                  busy,
    output logic                  done,
    raster_addr_gen_if.master     bus
);

    state_t r_state;
    state_t w_state_nxt;

    logic [X_WIDTH-1:0]    r_win_w;
    logic [Y_WIDTH-1:0]    r_win_h;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_line_base;

    logic                  w_zero_win;
    logic                  w_start_ok;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_x_tc;
    logic                  w_y_tc;
    logic [X_WIDTH-1:0]    w_x;
    logic [Y_WIDTH-1:0]    w_y;
    logic [X_WIDTH-1:0]    w_x_max;
    logic [Y_WIDTH-1:0]    w_y_max;

    assign w_zero_win = (win_w == '0) || (win_h == '0);
    assign w_start_ok = (r_state == ST_IDLE) && start && !w_zero_win;
    assign w_beat     = (r_state == ST_RUN) && bus.ready;
    assign w_last     = w_beat && w_x_tc && w_y_tc;

    // Terminal counts from the captured geometry; only meaningful in RUN,
    // where the captured width/height are known to be non-zero.
    assign w_x_max = r_win_w - X_WIDTH'(1);
    assign w_y_max = r_win_h - Y_WIDTH'(1);

    axis_counter #(.WIDTH(X_WIDTH)) u_x_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_beat && !w_x_tc),
        .i_sclr      (sclr),
        .i_load_zero (w_start_ok || (w_beat && w_x_tc)),
        .i_max       (w_x_max),
        .o_count     (w_x),
        .o_tc        (w_x_tc)
    );

    axis_counter #(.WIDTH(Y_WIDTH)) u_y_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_beat && w_x_tc && !w_y_tc),
        .i_sclr      (sclr),
        .i_load_zero (w_start_ok || w_last),
        .i_max       (w_y_max),
        .o_count     (w_y),
        .o_tc        (w_y_tc)
    );

    // Window geometry is frozen at an accepted start for the whole walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_w  <= '0;
            r_win_h  <= '0;
            r_stride <= '0;
        end else if (!sclr && w_start_ok) begin
            r_win_w  <= win_w;
            r_win_h  <= win_h;
            r_stride <= stride;
        end
    end

    // Incremental address: +1 along a line, line base + stride at line wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_line_base <= '0;
        end else if (sclr) begin
            r_addr      <= '0;
            r_line_base <= '0;
        end else if (w_start_ok) begin
            r_addr      <= base_addr;
            r_line_base <= base_addr;
        end else if (w_beat) begin
            if (!w_x_tc) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end else if (!w_y_tc) begin
                r_addr      <= r_line_base + r_stride;
                r_line_base <= r_line_base + r_stride;
            end else begin
                r_addr      <= '0;
                r_line_base <= '0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; sclr overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (sclr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_nxt = w_zero_win ? ST_DONE : ST_RUN;
                ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register only, so ready never reaches valid
    always_comb begin
        w_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_valid = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign bus.valid     = w_valid;
    assign bus.x         = w_x;
    assign bus.y         = w_y;
    assign bus.addr      = r_addr;
    assign bus.line_end  = w_valid && w_x_tc;
    assign bus.frame_end = w_valid && w_x_tc && w_y_tc;

endmodule

// File: tb/tb_raster_addr_gen.sv
// Self-checking bench for raster_addr_gen: a queue of expected beats is built
// from the window geometry with plain arithmetic and consumed on each transfer.
module tb_raster_addr_gen;

    localparam int XW   = 9;
    localparam int YW   = 9;
    localparam int AW   = 18;
    localparam int AMSK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sclr;
    logic          start;
    logic [XW-1:0] win_w;
    logic [YW-1:0] win_h;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic          busy;
    logic          done;

    raster_addr_gen_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)) bus ();

    raster_addr_gen #(.X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclr      (sclr),
        .start     (start),
        .win_w     (win_w),
        .win_h     (win_h),
        .base_addr (base_addr),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int addr;
        bit le;
        bit fe;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected raster: row-major walk, addr = base + y*stride + x mod 2^AW
    task automatic build_model(input int w, input int h, input int base, input int strd);
        beat_t b;
        exp_q.delete();
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                b.x    = xx;
                b.y    = yy;
                b.addr = (base + yy * strd + xx) & AMSK;
                b.le   = (xx == w - 1);
                b.fe   = (xx == w - 1) && (yy == h - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_x"},     32'(bus.x), 0);
        chk({tag, "_y"},     32'(bus.y), 0);
        chk({tag, "_addr"},  32'(bus.addr), 0);
        chk({tag, "_le"},    32'(bus.line_end), 0);
        chk({tag, "_fe"},    32'(bus.frame_end), 0);
    endtask

    // mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready.
    // sclr_at: beat index at which sclr is raised (-1 none).
    // restart_w: if >=0, start is held high through the walk with this width.
    task automatic run_window(input int w, input int h, input int base, input int strd,
                              input int mode, input int sclr_at, input int restart_w);
        int cyc;
        int idx;
        bit rdy;
        @(negedge clk);
        chk("pre_valid", 32'(bus.valid), 0);
        start     = 1'b1;
        win_w     = w[XW-1:0];
        win_h     = h[YW-1:0];
        base_addr = base[AW-1:0];
        stride    = strd[AW-1:0];
        build_model(w, h, base, strd);
        @(negedge clk);
        if (restart_w >= 0) begin
            win_w = restart_w[XW-1:0];
            base_addr = AW'($urandom_range(0, AMSK));
        end else begin
            start = 1'b0;
        end
        if (exp_q.size() == 0) begin
            start = 1'b0;
            chk("zero_valid", 32'(bus.valid), 0);
            chk("zero_done", 32'(done), 1);
            @(negedge clk);
            chk("zero_done_off", 32'(done), 0);
            chk("zero_valid_off", 32'(bus.valid), 0);
            return;
        end
        cyc = 0;
        idx = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            chk("valid", 32'(bus.valid), 1);
            chk("busy", 32'(busy), 1);
            chk("done_in_run", 32'(done), 0);
            chk("x", 32'(bus.x), exp_q[0].x);
            chk("y", 32'(bus.y), exp_q[0].y);
            chk("addr", 32'(bus.addr), exp_q[0].addr);
            chk("line_end", 32'(bus.line_end), 32'(exp_q[0].le));
            chk("frame_end", 32'(bus.frame_end), 32'(exp_q[0].fe));
            if (idx == sclr_at) begin
                sclr      = 1'b1;
                bus.ready = 1'b1;
                @(negedge clk);
                sclr      = 1'b0;
                start     = 1'b0;
                bus.ready = 1'b0;
                chk_quiet("sclr");
                @(negedge clk);
                chk("sclr_no_done", 32'(done), 0);
                chk("sclr_idle_valid", 32'(bus.valid), 0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            bus.ready = rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) chk("timeout", 1, 0);
        chk("end_valid", 32'(bus.valid), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_done", 32'(done), 1);
        @(negedge clk);
        chk("done_pulse_off", 32'(done), 0);
        chk("after_done_valid", 32'(bus.valid), 0);
        start = 1'b0;
    endtask

    initial begin
        int w;
        int h;
        int sa;
        int rw;
        rst_n     = 1'b0;
        sclr      = 1'b0;
        start     = 1'b0;
        bus.ready = 1'b0;
        win_w     = '0;
        win_h     = '0;
        base_addr = '0;
        stride    = '0;
        repeat (3) @(negedge clk);
        chk_quiet("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset");

        run_window(4, 3, 100, 8, 0, -1, -1);
        run_window(4, 3, 100, 8, 1, -1, -1);
        run_window(0, 5, 100, 8, 0, -1, -1);
        run_window(4, 3, 100, 8, 0, 6, -1);
        run_window(4, 3, 100, 8, 0, -1, -1);
        run_window(4, 1, 262142, 4, 0, -1, -1);
        run_window(4, 3, 100, 8, 2, -1, 7);
        run_window(1, 1, 55, 3, 0, -1, -1);
        run_window(6, 0, 7, 9, 0, -1, -1);

        // Reset in the middle of a walk
        @(negedge clk);
        start     = 1'b1;
        win_w     = 9'd5;
        win_h     = 9'd4;
        base_addr = 18'd10;
        stride    = 18'd20;
        @(negedge clk);
        start     = 1'b0;
        bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("mid_reset_release");
        run_window(3, 2, 500, 40, 0, -1, -1);

        for (int i = 0; i < 30; i++) begin
            w  = int'($urandom_range(0, 6));
            h  = int'($urandom_range(0, 5));
            sa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1;
            rw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
            run_window(w, h, int'($urandom_range(0, AMSK)), int'($urandom_range(0, AMSK)),
                       2, sa, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
